cal_qcol: RTL and testbench



---
 rtl/qr_pkg.sv | 42 ++++
 rtl/cal_qcol_recip_div.sv | 60 ++++++
 rtl/cal_qcol.sv | 102 ++++++++++
 tb/tb_cal_qcol.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared QR-decomposition definitions: widths, fixed-point formats, FSM encoding
// and the scale/round/saturate helper used by the Q-column stage.
package qr_pkg;

    localparam int unsigned H_W        = 24;
    localparam int unsigned RII_W      = 20;
    localparam int unsigned RECIP_W    = 37;
    localparam int unsigned H_FRAC     = 22;
    localparam int unsigned RII_FRAC   = 16;
    localparam int unsigned RECIP_FRAC = 20;
    localparam int unsigned N_ELEM     = 4;
    localparam int unsigned COL_W      = 2 * N_ELEM * H_W;

    localparam int unsigned PROD_W = H_W + RECIP_W + 1;
    localparam int unsigned SHR_W  = PROD_W - RECIP_FRAC;

    localparam logic signed [SHR_W-1:0] Q_MAX = SHR_W'(2 ** (H_W - 1) - 1);
    localparam logic signed [SHR_W-1:0] Q_MIN = SHR_W'(-(2 ** (H_W - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2
    } qr_state_e;

    // Signed 2.22 times unsigned 17.20 reciprocal, back to 2.22, round half up, saturate.
    function automatic logic [H_W-1:0] scale_rnd_sat(input logic [H_W-1:0]     x,
                                                     input logic [RECIP_W-1:0] r);
        logic signed [PROD_W-1:0] p;
        logic signed [SHR_W-1:0]  s;
        p = PROD_W'($signed(x)) * PROD_W'($signed({1'b0, r}));
        s = SHR_W'(p >>> RECIP_FRAC) + SHR_W'(p[RECIP_FRAC-1]);
        if (s > Q_MAX) begin
            scale_rnd_sat = {1'b0, {(H_W - 1){1'b1}}};
        end else if (s < Q_MIN) begin
            scale_rnd_sat = {1'b1, {(H_W - 1){1'b0}}};
        end else begin
            scale_rnd_sat = s[H_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cal_qcol_recip_div.sv
// Sequential restoring divider producing floor(2^36 / divisor), one quotient bit per cycle.
module recip_div
    import qr_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               start_i,
    input  logic [RII_W-1:0]   divisor_i,
    output logic               done_o,
    output logic [RECIP_W-1:0] quotient_o
);

    localparam int unsigned CNT_W = $clog2(RECIP_W);

    logic [RII_W-1:0]   divisor_q;
    logic [RII_W-1:0]   rem_q;
    logic [RECIP_W-1:0] quot_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q;

    logic [RII_W:0]   rem_sh;
    logic [RII_W-1:0] rem_sub;
    logic             ge;

    // Dividend is 2^36: only the first shifted-in bit is a one.
    always_comb begin
        rem_sh  = {rem_q, (cnt_q == '0)};
        rem_sub = rem_sh[RII_W-1:0] - divisor_q;
        ge      = (rem_sh >= {1'b0, divisor_q});
    end

    // High in the cycle whose clock edge shifts in the final quotient bit.
    assign done_o     = run_q && (cnt_q == CNT_W'(RECIP_W - 1));
    assign quotient_o = quot_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
        end else if (start_i) begin
            divisor_q <= divisor_i;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b1;
        end else if (run_q) begin
            rem_q  <= ge ? rem_sub : rem_sh[RII_W-1:0];
            quot_q <= {quot_q[RECIP_W-2:0], ge};
            if (done_o) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cal_qcol.sv
// Q-column normalisation q = h / Rii: reciprocal via restoring divider, then
// two multipliers scale one complex element per cycle.
module cal_qcol
    import qr_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [RII_W-1:0] Rii,
    input  logic             Rii_valid,
    input  logic [COL_W-1:0] h_column,
    output logic [COL_W-1:0] q_column,
    output logic             q_valid,
    output logic             busy,
    output logic             div0,
    output logic             drop
);

    qr_state_e        state_q;
    logic [1:0]       cnt_q;
    logic [COL_W-1:0] h_q;
    logic             rii_zero_q;

    logic               start_c;
    logic               div_done_c;
    logic [RECIP_W-1:0] quot_c;
    logic [RECIP_W-1:0] r_c;
    logic [H_W-1:0]     re_c;
    logic [H_W-1:0]     im_c;
    logic [H_W-1:0]     q_re_c;
    logic [H_W-1:0]     q_im_c;
    int unsigned        sel_c;

    assign start_c = (state_q == IDLE) && Rii_valid;

    recip_div u_recip_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .start_i    (start_c),
        .divisor_i  (Rii),
        .done_o     (div_done_c),
        .quotient_o (quot_c)
    );

    // Rii == 0 still runs the divider for constant latency; its result is discarded.
    always_comb begin
        sel_c  = 32'(cnt_q) * 2 * H_W;
        r_c    = rii_zero_q ? '0 : quot_c;
        re_c   = h_q[sel_c +: H_W];
        im_c   = h_q[sel_c + H_W +: H_W];
        q_re_c = scale_rnd_sat(re_c, r_c);
        q_im_c = scale_rnd_sat(im_c, r_c);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            h_q        <= '0;
            rii_zero_q <= 1'b0;
            q_column   <= '0;
            q_valid    <= 1'b0;
            busy       <= 1'b0;
            div0       <= 1'b0;
            drop       <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            div0    <= 1'b0;
            drop    <= Rii_valid && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (Rii_valid) begin
                        h_q        <= h_column;
                        rii_zero_q <= (Rii == '0);
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        state_q    <= DIV;
                    end
                end
                DIV: begin
                    if (div_done_c) begin
                        cnt_q   <= '0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    q_column[sel_c +: H_W]       <= q_re_c;
                    q_column[sel_c + H_W +: H_W] <= q_im_c;
                    if (cnt_q == 2'd3) begin
                        q_valid <= 1'b1;
                        div0    <= rii_zero_q;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cal_qcol.sv
// Directed table-driven bench for cal_qcol plus drop/back-to-back and reset-abort sequences.
module tb_cal_qcol;

    logic         clk;
    logic         rst;
    logic [19:0]  rii;
    logic         rii_valid;
    logic [191:0] h_col;
    logic [191:0] q_col;
    logic         q_valid;
    logic         busy;
    logic         div0;
    logic         drop;

    int n_chk = 0;
    int n_err = 0;

    cal_qcol dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .Rii       (rii),
        .Rii_valid (rii_valid),
        .h_column  (h_col),
        .q_column  (q_col),
        .q_valid   (q_valid),
        .busy      (busy),
        .div0      (div0),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [19:0]  rii;
        logic [191:0] h;
        logic [191:0] q;
        logic         div0;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [191:0] pk(input logic [23:0] r0, input logic [23:0] i0,
                                        input logic [23:0] r1, input logic [23:0] i1,
                                        input logic [23:0] r2, input logic [23:0] i2,
                                        input logic [23:0] r3, input logic [23:0] i3);
        pk = {i3, r3, i2, r2, i1, r1, i0, r0};
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; Rii_valid is sampled on the following posedge (E0).
    task automatic drive(input logic [19:0] r, input logic [191:0] h);
        rii       = r;
        h_col     = h;
        rii_valid = 1'b1;
        @(negedge clk);
        rii_valid = 1'b0;
    endtask

    // k = number of posedges after E0 when q_valid is first seen.
    task automatic wait_q(output int k, output int bn, output int dr);
        k  = 0;
        bn = busy ? 1 : 0;
        dr = drop ? 1 : 0;
        while (!q_valid && k < 100) begin
            @(negedge clk);
            k++;
            if (!q_valid && busy) bn++;
            if (drop) dr++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bn, dr, nq;

        // Rii = 1.0 -> R = 2^20; sqrt2 -> R = 741454; 0.5 -> R = 2^21; 3.0 -> R = 349525.
        vecs[0] = '{"unit_re0", 20'h10000, pk(24'h400000, 0, 0, 0, 0, 0, 0, 0),
                    pk(24'h400000, 0, 0, 0, 0, 0, 0, 0), 1'b0};
        vecs[1] = '{"half_sqrt2", 20'd92682,
                    pk(24'h200000, 24'h200000, 24'h200000, 24'h200000,
                       24'h200000, 24'h200000, 24'h200000, 24'h200000),
                    pk(24'h16A09C, 24'h16A09C, 24'h16A09C, 24'h16A09C,
                       24'h16A09C, 24'h16A09C, 24'h16A09C, 24'h16A09C), 1'b0};
        vecs[2] = '{"sign_quarter", 20'h10000, pk(24'hC00000, 0, 0, 0, 0, 24'h100000, 0, 0),
                    pk(24'hC00000, 0, 0, 0, 0, 24'h100000, 0, 0), 1'b0};
        vecs[3] = '{"rii_zero", 20'h0,
                    pk(24'h123456, 24'h7FFFFF, 24'h800000, 24'h000001,
                       24'hABCDEF, 24'h3FFFFF, 24'hC00000, 24'h0F0F0F),
                    '0, 1'b1};
        vecs[4] = '{"saturate", 20'h08000,
                    pk(24'h7FFFFF, 24'h800000, 24'h100000, 24'hFFFFFF, 0, 0, 0, 0),
                    pk(24'h7FFFFF, 24'h800000, 24'h200000, 24'hFFFFFE, 0, 0, 0, 0), 1'b0};
        vecs[5] = '{"rounding", 20'h30000,
                    pk(24'h400000, 24'h000003, 24'hFFFFFD, 24'h000002,
                       24'hFFFFFE, 24'h000000, 24'hC00000, 24'h000001),
                    pk(24'h155554, 24'h000001, 24'hFFFFFF, 24'h000001,
                       24'hFFFFFF, 24'h000000, 24'hEAAAAC, 24'h000000), 1'b0};

        rst       = 1'b1;
        rii       = '0;
        rii_valid = 1'b0;
        h_col     = '0;
        repeat (3) @(negedge clk);
        chk("reset_q_column", q_col, '0);
        chk("reset_flags", 192'({q_valid, busy, div0, drop}), '0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rii, vecs[i].h);
            wait_q(k, bn, dr);
            chk({vecs[i].name, "_latency"}, 192'(k), 192'(41));
            chk({vecs[i].name, "_q"}, q_col, vecs[i].q);
            chk({vecs[i].name, "_div0"}, 192'(div0), 192'(vecs[i].div0));
            chk({vecs[i].name, "_busy_cycles"}, 192'(bn), 192'(41));
            chk({vecs[i].name, "_no_drop"}, 192'(dr), '0);
            @(negedge clk);
            chk({vecs[i].name, "_pulse"}, 192'({q_valid, div0}), '0);
            repeat (2) @(negedge clk);
        end

        // Column arriving mid-DIV is dropped; one arriving on the q_valid cycle is accepted.
        drive(vecs[0].rii, vecs[0].h);
        repeat (10) @(negedge clk);
        rii       = vecs[4].rii;
        h_col     = vecs[4].h;
        rii_valid = 1'b1;
        @(negedge clk);
        rii_valid = 1'b0;
        chk("drop_pulse", 192'(drop), 192'(1));
        @(negedge clk);
        chk("drop_one_cycle", 192'(drop), '0);
        k  = 12;
        dr = 0;
        while (!q_valid && k < 100) begin
            @(negedge clk);
            k++;
            if (drop) dr++;
        end
        chk("drop_first_latency", 192'(k), 192'(41));
        chk("drop_first_q", q_col, vecs[0].q);
        chk("drop_no_extra", 192'(dr), '0);
        drive(vecs[2].rii, vecs[2].h);
        chk("b2b_accept_no_drop", 192'(drop), '0);
        wait_q(k, bn, dr);
        chk("b2b_latency", 192'(k), 192'(41));
        chk("b2b_q", q_col, vecs[2].q);
        chk("b2b_no_drop", 192'(dr), '0);
        repeat (2) @(negedge clk);

        // Reset during DIV aborts the column with no stale q_valid.
        drive(vecs[4].rii, vecs[4].h);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_q_column", q_col, '0);
        chk("abort_flags", 192'({q_valid, busy, div0, drop}), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nq  = 0;
        repeat (60) begin
            @(negedge clk);
            if (q_valid || busy) nq++;
        end
        chk("abort_no_stale", 192'(nq), '0);
        drive(vecs[0].rii, vecs[0].h);
        wait_q(k, bn, dr);
        chk("abort_after_latency", 192'(k), 192'(41));
        chk("abort_after_q", q_col, vecs[0].q);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
